reservation_station_param: RTL and testbench

- Parametrised successor to the ALU reservation station.
- Holds up to RS_DEPTH decoded ops waiting on ROB-tagged operands and snoops CDB_N result buses to wake them.
- Issues one ready op per cycle to the ALU under a valid/ready handshake, and supports a full pipeline flush on mispredict.
- Sits between the decoder/dispatch stage and the ALU; reports capacity and occupancy back to dispatch.

---
 rtl/reservation_station_param.sv | 230 +++++++++++++++++++++++
 tb/tb_reservation_station_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_param.sv
// Parametrised ALU reservation station: CDB wakeup, same-cycle bypass, one issue per cycle.
// Optional RS_AGE_ISSUE_EN: oldest-ready issue via an age matrix (default: lowest-index ready).
module reservation_station_param #(
    parameter int RS_DEPTH = 16,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 5,
    parameter int OP_W     = 6,
    parameter int CDB_N    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          flush,
    input  logic                          assign_valid,
    input  logic [OP_W-1:0]               in_op,
    input  logic [DATA_W-1:0]             in_imm,
    input  logic [DATA_W-1:0]             in_pc,
    input  logic [ROB_W-1:0]              in_Qj,
    input  logic [ROB_W-1:0]              in_Qk,
    input  logic [DATA_W-1:0]             in_Vj,
    input  logic [DATA_W-1:0]             in_Vk,
    input  logic [ROB_W-1:0]              in_rd_rob,
    input  logic                          in_has_rd_dest,
    input  logic [CDB_N-1:0]              cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]        cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]       cdb_data,
    input  logic                          alu_ready,
    output logic                          out_valid,
    output logic [OP_W-1:0]               out_op,
    output logic [DATA_W-1:0]             out_Vj,
    output logic [DATA_W-1:0]             out_Vk,
    output logic [ROB_W-1:0]              out_rob_tag,
    output logic [DATA_W-1:0]             out_pc,
    output logic [DATA_W-1:0]             out_imm,
    output logic                          has_capacity,
    output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int OCC_W = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [OP_W-1:0]     op_q  [RS_DEPTH], op_d  [RS_DEPTH];
    logic [DATA_W-1:0]   imm_q [RS_DEPTH], imm_d [RS_DEPTH];
    logic [DATA_W-1:0]   pc_q  [RS_DEPTH], pc_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_q  [RS_DEPTH], vj_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_q  [RS_DEPTH], vk_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q  [RS_DEPTH], qj_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q  [RS_DEPTH], qk_d  [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q [RS_DEPTH], rob_d [RS_DEPTH];

    logic                out_valid_q, out_valid_d;
    logic [OP_W-1:0]     out_op_q, out_op_d;
    logic [DATA_W-1:0]   out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0]   out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [ROB_W-1:0]    out_rob_q, out_rob_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic [RS_DEPTH-1:0] ready, cand;
    logic [IDX_W-1:0]    iss_idx, alloc_idx;
    logic                iss_found, alloc_found, do_issue, do_assign;
    logic [DATA_W:0]     byp_j, byp_k;
    logic [DATA_W:0]     wk_j [RS_DEPTH], wk_k [RS_DEPTH];

`ifdef RS_AGE_ISSUE_EN
    // age_q[r][c] set: entry r was already waiting when entry c was allocated
    logic [RS_DEPTH-1:0] age_q [RS_DEPTH], age_d [RS_DEPTH];
`endif

    // Returns {hit, data}; lowest channel wins when several carry the same tag.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int unsigned k = 0; k < CDB_N; k++) begin
            if (!r[DATA_W] && cdb_valid[k] && tag != '0 && cdb_tag[k*ROB_W +: ROB_W] == tag)
                r = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++)
            ready[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
`ifdef RS_AGE_ISSUE_EN
        cand = ready;
        for (int unsigned i = 0; i < RS_DEPTH; i++)
            for (int unsigned j = 0; j < RS_DEPTH; j++)
                if (ready[j] && age_q[j][i]) cand[i] = 1'b0;
`else
        cand = ready;
`endif
        iss_found   = 1'b0;
        iss_idx     = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && !iss_found) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
            if (!busy_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    assign has_capacity = ~&busy_q;
    assign do_issue     = alu_ready && iss_found;
    assign do_assign    = assign_valid && alloc_found;
    assign byp_j        = cdb_lookup(in_Qj);
    assign byp_k        = cdb_lookup(in_Qk);

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        rob_d  = rob_q;
        out_valid_d = 1'b0;
        out_op_d    = '0;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_rob_d   = out_rob_q;
        occ_d       = occ_q;
`ifdef RS_AGE_ISSUE_EN
        age_d = age_q;
`endif
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            wk_j[i] = cdb_lookup(qj_q[i]);
            wk_k[i] = cdb_lookup(qk_q[i]);
            if (busy_q[i] && wk_j[i][DATA_W]) begin
                qj_d[i] = '0;
                vj_d[i] = wk_j[i][DATA_W-1:0];
            end
            if (busy_q[i] && wk_k[i][DATA_W]) begin
                qk_d[i] = '0;
                vk_d[i] = wk_k[i][DATA_W-1:0];
            end
        end
        if (do_issue) begin
            busy_d[iss_idx] = 1'b0;
            out_valid_d = 1'b1;
            out_op_d    = op_q[iss_idx];
            out_vj_d    = vj_q[iss_idx];
            out_vk_d    = vk_q[iss_idx];
            out_pc_d    = pc_q[iss_idx];
            out_imm_d   = imm_q[iss_idx];
            out_rob_d   = rob_q[iss_idx];
        end
        if (do_assign) begin
            busy_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]   = in_op;
            imm_d[alloc_idx]  = in_imm;
            pc_d[alloc_idx]   = in_pc;
            rob_d[alloc_idx]  = in_has_rd_dest ? in_rd_rob : '0;
            qj_d[alloc_idx]   = byp_j[DATA_W] ? '0 : in_Qj;
            vj_d[alloc_idx]   = byp_j[DATA_W] ? byp_j[DATA_W-1:0] : in_Vj;
            qk_d[alloc_idx]   = byp_k[DATA_W] ? '0 : in_Qk;
            vk_d[alloc_idx]   = byp_k[DATA_W] ? byp_k[DATA_W-1:0] : in_Vk;
`ifdef RS_AGE_ISSUE_EN
            age_d[alloc_idx] = '0;
            for (int unsigned r = 0; r < RS_DEPTH; r++)
                if (busy_q[r]) age_d[r][alloc_idx] = 1'b1;
`endif
        end
        if (do_assign && !do_issue)      occ_d = occ_q + 1'b1;
        else if (do_issue && !do_assign) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || (ena && flush)) begin
            busy_q      <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_rob_q   <= '0;
`ifdef RS_AGE_ISSUE_EN
            for (int unsigned i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
`endif
        end else if (ena) begin
            busy_q      <= busy_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_pc_q    <= out_pc_d;
            out_imm_q   <= out_imm_d;
            out_rob_q   <= out_rob_d;
`ifdef RS_AGE_ISSUE_EN
            age_q <= age_d;
`endif
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ena) begin
            op_q  <= op_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            rob_q <= rob_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_Vj      = out_vj_q;
    assign out_Vk      = out_vk_q;
    assign out_rob_tag = out_rob_q;
    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_reservation_station_param.sv
// Self-checking bench for reservation_station_param: directed scenarios plus random traffic
// compared against a slot/sequence-number reference model.
module tb_reservation_station_param;
    localparam int RS_DEPTH = 16;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = 5;
    localparam int OP_W     = 6;
    localparam int CDB_N    = 2;
    localparam int OCC_W    = $clog2(RS_DEPTH+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, ena, flush, assign_valid, in_has_rd_dest, alu_ready;
    logic [OP_W-1:0]         in_op;
    logic [DATA_W-1:0]       in_imm, in_pc, in_Vj, in_Vk;
    logic [ROB_W-1:0]        in_Qj, in_Qk, in_rd_rob;
    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*ROB_W-1:0]  cdb_tag;
    logic [CDB_N*DATA_W-1:0] cdb_data;
    logic                    out_valid, has_capacity;
    logic [OP_W-1:0]         out_op;
    logic [DATA_W-1:0]       out_Vj, out_Vk, out_pc, out_imm;
    logic [ROB_W-1:0]        out_rob_tag;
    logic [OCC_W-1:0]        occupancy;

    reservation_station_param #(
        .RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush), .assign_valid(assign_valid),
        .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc), .in_Qj(in_Qj), .in_Qk(in_Qk),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_rd_rob(in_rd_rob), .in_has_rd_dest(in_has_rd_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .alu_ready(alu_ready),
        .out_valid(out_valid), .out_op(out_op), .out_Vj(out_Vj), .out_Vk(out_Vk),
        .out_rob_tag(out_rob_tag), .out_pc(out_pc), .out_imm(out_imm),
        .has_capacity(has_capacity), .occupancy(occupancy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one record per slot, age kept as an allocation sequence number.
    typedef struct {
        bit                busy;
        longint unsigned   seq;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm, pc, vj, vk;
        logic [ROB_W-1:0]  qj, qk, rob;
    } ent_t;

    ent_t              m [RS_DEPTH];
    longint unsigned   seq_ctr = 0;
    bit                e_valid;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_vj, e_vk, e_pc, e_imm;
    logic [ROB_W-1:0]  e_rob;

    function automatic bit cdb_hit(input logic [ROB_W-1:0] tag, output logic [DATA_W-1:0] data);
        data = '0;
        if (tag == 0) return 1'b0;
        for (int k = 0; k < CDB_N; k++)
            if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag) begin
                data = cdb_data[k*DATA_W +: DATA_W];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RS_DEPTH; i++) m[i].busy = 1'b0;
        e_valid = 0; e_op = '0; e_vj = '0; e_vk = '0; e_pc = '0; e_imm = '0; e_rob = '0;
    endtask

    task automatic model_step();
        int pick = -1;
        int free = -1;
        logic [DATA_W-1:0] d;
        if (rst) begin model_clear(); return; end
        if (!ena) return;
        if (flush) begin model_clear(); return; end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) begin
`ifdef RS_AGE_ISSUE_EN
                if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
            if (!m[i].busy && free < 0) free = i;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!m[i].busy) continue;
            if (cdb_hit(m[i].qj, d)) begin m[i].qj = 0; m[i].vj = d; end
            if (cdb_hit(m[i].qk, d)) begin m[i].qk = 0; m[i].vk = d; end
        end
        e_valid = 0;
        e_op    = '0;
        if (pick >= 0 && alu_ready) begin
            e_valid = 1;
            e_op  = m[pick].op;  e_vj = m[pick].vj;  e_vk = m[pick].vk;
            e_pc  = m[pick].pc;  e_imm = m[pick].imm; e_rob = m[pick].rob;
            m[pick].busy = 1'b0;
        end
        if (assign_valid && free >= 0) begin
            m[free].busy = 1'b1;
            m[free].seq  = seq_ctr++;
            m[free].op   = in_op;
            m[free].imm  = in_imm;
            m[free].pc   = in_pc;
            m[free].rob  = in_has_rd_dest ? in_rd_rob : '0;
            if (cdb_hit(in_Qj, d)) begin m[free].qj = 0; m[free].vj = d; end
            else begin m[free].qj = in_Qj; m[free].vj = in_Vj; end
            if (cdb_hit(in_Qk, d)) begin m[free].qk = 0; m[free].vk = d; end
            else begin m[free].qk = in_Qk; m[free].vk = in_Vk; end
        end
    endtask

    task automatic compare_all();
        int occ = 0;
        for (int i = 0; i < RS_DEPTH; i++) occ += int'(m[i].busy);
        check("out_valid", out_valid, e_valid);
        check("out_op", out_op, e_op);
        check("out_Vj", out_Vj, e_vj);
        check("out_Vk", out_Vk, e_vk);
        check("out_pc", out_pc, e_pc);
        check("out_imm", out_imm, e_imm);
        check("out_rob_tag", out_rob_tag, e_rob);
        check("occupancy", occupancy, occ);
        check("has_capacity", has_capacity, occ < RS_DEPTH);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        rst = 0; ena = 1; flush = 0; assign_valid = 0; alu_ready = 1;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic put_op(input int op, input int qj, input int qk, input int vj, input int vk, input int rd);
        assign_valid   = 1;
        in_op          = OP_W'(op);
        in_Qj          = ROB_W'(qj);
        in_Qk          = ROB_W'(qk);
        in_Vj          = DATA_W'(vj);
        in_Vk          = DATA_W'(vk);
        in_rd_rob      = ROB_W'(rd);
        in_has_rd_dest = 1;
        in_pc          = $urandom;
        in_imm         = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [OP_W-1:0] ord [3];
        idle();
        in_op = '0; in_imm = '0; in_pc = '0; in_Qj = '0; in_Qk = '0;
        in_Vj = '0; in_Vk = '0; in_rd_rob = '0; in_has_rd_dest = 0;
        model_clear();
        rst = 1;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_cap", has_capacity, 1);

        // Minimum latency
        idle(); put_op(3, 0, 0, 5, 7, 4); tick();
        idle(); tick();
        check("lat_valid", out_valid, 1);
        check("lat_op", out_op, 3);
        check("lat_vj", out_Vj, 5);
        check("lat_vk", out_Vk, 7);
        check("lat_rob", out_rob_tag, 4);
        check("lat_occ", occupancy, 0);

        // Wakeup from CDB channel 1
        idle(); put_op(11, 6, 0, 1, 2, 3); tick();
        idle(); tick();
        cdb_valid = 2'b10; cdb_tag = {ROB_W'(6), ROB_W'(0)}; cdb_data = {32'h55, 32'h0};
        tick();
        check("wk_noissue", out_valid, 0);
        idle(); tick();
        check("wk_valid", out_valid, 1);
        check("wk_vj", out_Vj, 32'h55);

        // Same-cycle bypass on channel 0
        idle(); put_op(12, 0, 9, 3, 4, 5);
        cdb_valid = 2'b01; cdb_tag = {ROB_W'(0), ROB_W'(9)}; cdb_data = {32'h0, 32'hAA};
        tick();
        idle(); tick();
        check("byp_valid", out_valid, 1);
        check("byp_vk", out_Vk, 32'hAA);

        // Fill to capacity, overflow, drain
        idle(); alu_ready = 0;
        for (int i = 0; i < RS_DEPTH; i++) begin put_op(i + 1, 0, 0, i, i, i); tick(); end
        check("full_cap", has_capacity, 0);
        check("full_occ", occupancy, RS_DEPTH);
        put_op(40, 0, 0, 0, 0, 0); tick();
        check("full_occ17", occupancy, RS_DEPTH);
        idle(); n = 0;
        repeat (RS_DEPTH) begin tick(); n += int'(out_valid); end
        check("drain_cnt", n, RS_DEPTH);
        tick();
        check("drain_empty", out_valid, 0);

        // Flush with 8 busy entries and a simultaneous assign
        idle(); alu_ready = 0;
        for (int i = 0; i < 8; i++) begin put_op(20 + i, 0, 0, i, i, 1); tick(); end
        check("pre_flush_occ", occupancy, 8);
        put_op(30, 0, 0, 0, 0, 1); flush = 1; tick();
        check("flush_occ", occupancy, 0);
        check("flush_valid", out_valid, 0);
        idle();
        repeat (3) tick();

        // Issue order after slot reuse
        idle(); alu_ready = 0;
        put_op(1, 0, 0, 0, 0, 1); tick();
        put_op(2, 7, 0, 0, 0, 2); tick();
        put_op(3, 7, 0, 0, 0, 3); tick();
        idle(); tick();
        check("ord_a", out_op, 1);
        idle(); alu_ready = 0; put_op(4, 0, 0, 0, 0, 4); tick();
        idle(); alu_ready = 0;
        cdb_valid = 2'b01; cdb_tag = {ROB_W'(0), ROB_W'(7)}; cdb_data = {32'h0, 32'h77};
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin tick(); ord[i] = out_op; end
`ifdef RS_AGE_ISSUE_EN
        check("ord_0", ord[0], 2); check("ord_1", ord[1], 3); check("ord_2", ord[2], 4);
`else
        check("ord_0", ord[0], 4); check("ord_1", ord[1], 2); check("ord_2", ord[2], 3);
`endif

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            ena            = ($urandom_range(0, 15) != 0);
            flush          = ($urandom_range(0, 59) == 0);
            assign_valid   = ($urandom_range(0, 2) != 0);
            alu_ready      = ($urandom_range(0, 3) != 0);
            in_op          = OP_W'($urandom);
            in_Qj          = $urandom_range(0, 1) ? '0 : ROB_W'($urandom_range(1, 7));
            in_Qk          = $urandom_range(0, 1) ? '0 : ROB_W'($urandom_range(1, 7));
            in_Vj          = $urandom;
            in_Vk          = $urandom;
            in_pc          = $urandom;
            in_imm         = $urandom;
            in_rd_rob      = ROB_W'($urandom);
            in_has_rd_dest = 1'($urandom);
            cdb_valid      = CDB_N'($urandom);
            for (int k = 0; k < CDB_N; k++) begin
                cdb_tag[k*ROB_W +: ROB_W]   = ROB_W'($urandom_range(0, 7));
                cdb_data[k*DATA_W +: DATA_W] = $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
